regintf_arbiter: RTL and testbench

REGINTF_ARBITER -- requirements
Module: regintf_arbiter

---
 rtl/regintf_arbiter.sv | 124 ++++++++++++
 tb/tb_regintf_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regintf_arbiter.sv
// rtl/regintf_arbiter.sv - two-port register-interface arbiter with read wait and layer-execution wait
// Optional: define REGARB_ROUND_ROBIN_EN for round-robin tie-break (default fixed priority, port 0 wins).
module regintf_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [13:0] addr0,
  input  logic [13:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [15:0] rdata,
  output logic        wr_en,
  output logic        rd_en,
  output logic [13:0] addr_out,
  output logic [15:0] write_data,
  input  logic [15:0] read_data,
  input  logic        done_executing,
  output logic        exec_busy,
  output logic        next_layer
);

  typedef enum logic [1:0] {IDLE, ISSUE, READ_WAIT, EXEC_WAIT} state_t;

  state_t      state;
  logic        winner;
  logic        win_we;
  logic [13:0] win_addr;
  logic [15:0] win_wdata;

`ifdef REGARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  // Writes into the 7'h01 region, and the layer-start register itself, hold off
  // further traffic until the controller reports the layer is done.
  function automatic logic is_exec_addr(input logic [13:0] a);
    return (a[13:7] == 7'h01) || (a == 14'h0001);
  endfunction

  // Choose the port to serve among the currently requesting ones
  always_comb begin
    winner = ~req[0];
`ifdef REGARB_ROUND_ROBIN_EN
    if (req == 2'b11) begin
      winner = ~last_grant;
    end
`endif
    win_we    = winner ? we[1]  : we[0];
    win_addr  = winner ? addr1  : addr0;
    win_wdata = winner ? wdata1 : wdata0;
  end

  // Read data is a pass-through of the register file during the read-wait cycle only
  assign rdata = (state == READ_WAIT) ? read_data : 16'h0000;

  // Arbitration FSM; the issued op is remembered in addr_out/wr_en/gnt themselves
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      rvalid     <= 2'b00;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      addr_out   <= 14'h0000;
      write_data <= 16'h0000;
      exec_busy  <= 1'b0;
      next_layer <= 1'b0;
`ifdef REGARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          rvalid    <= 2'b00;
          exec_busy <= 1'b0;
          if (req != 2'b00) begin
            state      <= ISSUE;
            gnt        <= winner ? 2'b10 : 2'b01;
            wr_en      <= win_we;
            rd_en      <= ~win_we;
            addr_out   <= win_addr;
            write_data <= win_wdata;
            next_layer <= win_we && (win_addr == 14'h0001);
`ifdef REGARB_ROUND_ROBIN_EN
            last_grant <= winner;
`endif
          end
        end
        ISSUE: begin
          gnt        <= 2'b00;
          wr_en      <= 1'b0;
          rd_en      <= 1'b0;
          next_layer <= 1'b0;
          if (rd_en) begin
            state  <= READ_WAIT;
            rvalid <= gnt;
          end else if (is_exec_addr(addr_out)) begin
            state     <= EXEC_WAIT;
            exec_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        READ_WAIT: begin
          rvalid <= 2'b00;
          state  <= IDLE;
        end
        EXEC_WAIT: begin
          if (done_executing) begin
            exec_busy <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regintf_arbiter.sv
// tb/tb_regintf_arbiter.sv - randomized bench with a transaction-schedule reference model
module tb_regintf_arbiter;

  localparam int NCYC = 6000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [13:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        wr_en, rd_en;
  logic [13:0] addr_out;
  logic [15:0] write_data;
  logic [15:0] read_data = '0;
  logic        done_executing = 1'b0;
  logic        exec_busy, next_layer;

  regintf_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .wr_en(wr_en), .rd_en(rd_en),
    .addr_out(addr_out), .write_data(write_data), .read_data(read_data),
    .done_executing(done_executing), .exec_busy(exec_busy), .next_layer(next_layer)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected per-cycle outputs, scheduled by the model when a request is accepted
  logic [1:0]  e_gnt   [0:NCYC+4];
  logic [1:0]  e_rv    [0:NCYC+4];
  logic        e_wr    [0:NCYC+4];
  logic        e_rd    [0:NCYC+4];
  logic        e_nl    [0:NCYC+4];
  logic [13:0] e_addr  [0:NCYC+4];
  logic [15:0] e_wd    [0:NCYC+4];

  // Model state: when the arbiter next accepts a request, and layer-execution wait
  int          idle_from = 0;
  bit          in_exec = 0;
  int          exec_start = 0;
  bit          lg = 1'b1;
  logic [13:0] m_addr = '0;
  logic [15:0] m_wdata = '0;

  // Requester-side pending operations
  bit          r_act [2];
  logic        r_we  [2];
  logic [13:0] r_addr[2];
  logic [15:0] r_wd  [2];

  function automatic logic [13:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 14'h0001;
      1: return 14'h0080 | 14'($urandom_range(0, 127));
      2: return 14'h0200;
      default: return 14'($urandom);
    endcase
  endfunction

  initial begin
    int  w;
    bit  exec_w;
    for (int k = 0; k <= NCYC + 4; k++) begin
      e_gnt[k] = '0; e_rv[k] = '0; e_wr[k] = 0; e_rd[k] = 0; e_nl[k] = 0;
      e_addr[k] = '0; e_wd[k] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      r_act[p] = 0; r_we[p] = 0; r_addr[p] = '0; r_wd[p] = '0;
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      // Drive this cycle's inputs
      rst = (c < 2) || ($urandom_range(0, 149) == 0);
      for (int p = 0; p < 2; p++) begin
        if (c >= 1 && e_gnt[c-1][p]) r_act[p] = 0;
        if (!r_act[p] && $urandom_range(0, 2) == 0) begin
          r_act[p]  = 1;
          r_we[p]   = 1'($urandom);
          r_addr[p] = pick_addr();
          r_wd[p]   = 16'($urandom);
        end
      end
      req    = {r_act[1], r_act[0]};
      we     = {r_we[1], r_we[0]};
      addr0  = r_addr[0];
      addr1  = r_addr[1];
      wdata0 = r_wd[0];
      wdata1 = r_wd[1];
      done_executing = ($urandom_range(0, 5) == 0);
      read_data = 16'($urandom);

      @(negedge clk);
      // Compare outputs of this cycle against the schedule
      if (c >= 1) begin
        if (e_gnt[c] != 2'b00) begin
          m_addr  = e_addr[c];
          m_wdata = e_wd[c];
        end
        check("gnt", c, 32'(gnt), 32'(e_gnt[c]));
        check("wr_en", c, 32'(wr_en), 32'(e_wr[c]));
        check("rd_en", c, 32'(rd_en), 32'(e_rd[c]));
        check("next_layer", c, 32'(next_layer), 32'(e_nl[c]));
        check("rvalid", c, 32'(rvalid), 32'(e_rv[c]));
        if (e_rv[c] != 2'b00) check("rdata", c, 32'(rdata), 32'(read_data));
        if (c == 2) check("rdata_reset", c, 32'(rdata), 32'h0);
        check("exec_busy", c, 32'(exec_busy), 32'(in_exec && c >= exec_start));
        check("addr_out", c, 32'(addr_out), 32'(m_addr));
        check("write_data", c, 32'(write_data), 32'(m_wdata));
      end

      // Advance the model with this cycle's inputs
      if (rst) begin
        for (int k = c + 1; k <= c + 3; k++) begin
          e_gnt[k] = '0; e_rv[k] = '0; e_wr[k] = 0; e_rd[k] = 0; e_nl[k] = 0;
        end
        in_exec   = 0;
        idle_from = c + 1;
        lg        = 1'b1;
        m_addr    = '0;
        m_wdata   = '0;
      end else if (in_exec) begin
        if (c >= exec_start && done_executing) begin
          in_exec   = 0;
          idle_from = c + 1;
        end
      end else if (c >= idle_from && req != 2'b00) begin
`ifdef REGARB_ROUND_ROBIN_EN
        if (req == 2'b11) w = lg ? 0 : 1;
        else w = req[1] ? 1 : 0;
`else
        w = req[0] ? 0 : 1;
`endif
        lg = (w == 1);
        e_gnt[c+1]  = (w == 1) ? 2'b10 : 2'b01;
        e_wr[c+1]   = r_we[w];
        e_rd[c+1]   = !r_we[w];
        e_addr[c+1] = r_addr[w];
        e_wd[c+1]   = r_wd[w];
        e_nl[c+1]   = r_we[w] && (r_addr[w] == 14'h0001);
        exec_w = r_we[w] && ((r_addr[w] >= 14'h0080 && r_addr[w] <= 14'h00FF) || r_addr[w] == 14'h0001);
        if (!r_we[w]) begin
          e_rv[c+2] = e_gnt[c+1];
          idle_from = c + 3;
        end else if (exec_w) begin
          in_exec    = 1;
          exec_start = c + 2;
        end else begin
          idle_from = c + 2;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
